rps_match_controller: RTL and testbench

- Sequences a multi-round stone/paper/scissors match around the existing single-round judge.
- Collects one move per player per round through valid/ready handshakes and drives the judge through a req/ack handshake.
- Keeps the per-player scores and round count, and declares the match winner.
- Sits between the player-input logic and the round judge; its score and status outputs feed the top-level output mux.

---
 rtl/rps_match_if.sv | 33 +++
 rtl/rps_match_controller.sv | 174 +++++++++++++++++
 tb/tb_rps_match_controller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rps_match_if.sv
// rps_match_if: player move and round-judge handshakes
// master = match controller, slave = players/judge side
interface rps_match_if;
  logic       p1_valid;
  logic [1:0] p1_move;
  logic       p1_ready;
  logic       p2_valid;
  logic [1:0] p2_move;
  logic       p2_ready;
  logic       eval_req;
  logic [1:0] eval_p1;
  logic [1:0] eval_p2;
  logic       eval_ack;
  logic [1:0] eval_winner;

  modport master (
    input  p1_valid, p1_move,
    output p1_ready,
    input  p2_valid, p2_move,
    output p2_ready,
    output eval_req, eval_p1, eval_p2,
    input  eval_ack, eval_winner
  );

  modport slave (
    output p1_valid, p1_move,
    input  p1_ready,
    output p2_valid, p2_move,
    input  p2_ready,
    input  eval_req, eval_p1, eval_p2,
    output eval_ack, eval_winner
  );
endinterface

// File: rtl/rps_match_controller.sv
// rps_match_controller: multi-round stone/paper/scissors sequencer
// collects moves, drives the judge, keeps score, declares the winner
module rps_match_controller #(
  parameter int ROUNDS_TO_WIN  = 2,
  parameter int MAX_ROUNDS     = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        match_start,
  rps_match_if.master bus,
  output logic [3:0]  p1_score,
  output logic [3:0]  p2_score,
  output logic [3:0]  round_cnt,
  output logic        match_done,
  output logic [1:0]  match_winner,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    COLLECT = 3'b001,
    EVAL    = 3'b010,
    UPDATE  = 3'b011,
    DONE    = 3'b100
  } state_t;

  localparam logic [3:0]  WIN_N    = 4'(ROUNDS_TO_WIN);
  localparam logic [3:0]  MAX_N    = 4'(MAX_ROUNDS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t      state;
  logic        p1_have;
  logic        p2_have;
  logic [1:0]  mv1;
  logic [1:0]  mv2;
  logic [15:0] tmo_cnt;
  logic [1:0]  result;

  logic        p1_acc;
  logic        p2_acc;
  logic        h1_nxt;
  logic        h2_nxt;
  logic        tmo_hit;
  logic [1:0]  tmo_res;
  logic [3:0]  s1_nxt;
  logic [3:0]  s2_nxt;
  logic [3:0]  rnd_nxt;
  logic [1:0]  cap_win;

  assign bus.p1_ready = (state == COLLECT) && !p1_have;
  assign bus.p2_ready = (state == COLLECT) && !p2_have;
  assign bus.eval_req = (state == EVAL);
  assign bus.eval_p1  = mv1;
  assign bus.eval_p2  = mv2;
  assign state_dbg    = state;

  assign p1_acc  = bus.p1_valid && bus.p1_ready && (bus.p1_move != 2'b11);
  assign p2_acc  = bus.p2_valid && bus.p2_ready && (bus.p2_move != 2'b11);
  assign h1_nxt  = p1_have || p1_acc;
  assign h2_nxt  = p2_have || p2_acc;
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

  // timed-out round goes to whoever managed to submit, else a tie
  always_comb begin
    tmo_res = 2'b00;
    unique case (1'b1)
      (h1_nxt && !h2_nxt): tmo_res = 2'b01;
      (h2_nxt && !h1_nxt): tmo_res = 2'b10;
      default:             tmo_res = 2'b00;
    endcase
  end

  // post-round scores; 00 and 11 results both count as a tie
  always_comb begin
    s1_nxt  = p1_score;
    s2_nxt  = p2_score;
    rnd_nxt = round_cnt + 4'd1;
    if (result == 2'b01) s1_nxt = p1_score + 4'd1;
    if (result == 2'b10) s2_nxt = p2_score + 4'd1;
    cap_win = 2'b00;
    if (s1_nxt > s2_nxt) cap_win = 2'b01;
    if (s2_nxt > s1_nxt) cap_win = 2'b10;
  end

  // match sequencer with score and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      p1_have      <= 1'b0;
      p2_have      <= 1'b0;
      mv1          <= 2'b00;
      mv2          <= 2'b00;
      tmo_cnt      <= '0;
      result       <= 2'b00;
      p1_score     <= 4'd0;
      p2_score     <= 4'd0;
      round_cnt    <= 4'd0;
      match_done   <= 1'b0;
      match_winner <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (match_start) begin
            state        <= COLLECT;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
            round_cnt    <= 4'd0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
            p1_have      <= 1'b0;
            p2_have      <= 1'b0;
            tmo_cnt      <= '0;
          end
        end
        COLLECT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (p1_acc) begin
            mv1     <= bus.p1_move;
            p1_have <= 1'b1;
          end
          if (p2_acc) begin
            mv2     <= bus.p2_move;
            p2_have <= 1'b1;
          end
          if (h1_nxt && h2_nxt) begin
            state <= EVAL;
          end else if (tmo_hit) begin
            result <= tmo_res;
            state  <= UPDATE;
          end
        end
        EVAL: begin
          if (bus.eval_ack) begin
            result <= bus.eval_winner;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          round_cnt <= rnd_nxt;
          p1_score  <= s1_nxt;
          p2_score  <= s2_nxt;
          p1_have   <= 1'b0;
          p2_have   <= 1'b0;
          tmo_cnt   <= '0;
          if (s1_nxt == WIN_N) begin
            state        <= DONE;
            match_done   <= 1'b1;
            match_winner <= 2'b01;
          end else if (s2_nxt == WIN_N) begin
            state        <= DONE;
            match_done   <= 1'b1;
            match_winner <= 2'b10;
          end else if (rnd_nxt == MAX_N) begin
            state        <= DONE;
            match_done   <= 1'b1;
            match_winner <= cap_win;
          end else begin
            state <= COLLECT;
          end
        end
        DONE: begin
          if (!match_start) begin
            state      <= IDLE;
            match_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// tb_rps_match_controller: directed checks of the match controller
// instance uses ROUNDS_TO_WIN=2, MAX_ROUNDS=3, TIMEOUT_CYCLES=8
module tb_rps_match_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       match_start;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] round_cnt;
  logic       match_done;
  logic [1:0] match_winner;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  rps_match_if bus();

  rps_match_controller #(
    .ROUNDS_TO_WIN (2),
    .MAX_ROUNDS    (3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .match_start (match_start),
    .bus         (bus),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .round_cnt   (round_cnt),
    .match_done  (match_done),
    .match_winner(match_winner),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // both players submit together; judge acks in the first EVAL cycle
  task automatic play(input logic [1:0] m1, input logic [1:0] m2,
                      input logic [1:0] w, input string tag);
    bus.p1_valid = 1'b1;
    bus.p1_move  = m1;
    bus.p2_valid = 1'b1;
    bus.p2_move  = m2;
    step();
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    chk({tag, ".eval_state"}, 8'(state_dbg), 8'h2);
    chk({tag, ".eval_req"}, 8'(bus.eval_req), 8'h1);
    chk({tag, ".eval_p1"}, 8'(bus.eval_p1), 8'(m1));
    chk({tag, ".eval_p2"}, 8'(bus.eval_p2), 8'(m2));
    bus.eval_ack    = 1'b1;
    bus.eval_winner = w;
    step();
    bus.eval_ack = 1'b0;
    chk({tag, ".upd_state"}, 8'(state_dbg), 8'h3);
    step();
  endtask

  // round that ends on the COLLECT timeout; optionally P2 submits
  task automatic timeout_round(input logic p2sub, input string tag);
    int   n = 0;
    logic saw_req = 1'b0;
    if (p2sub) begin
      bus.p2_valid = 1'b1;
      bus.p2_move  = 2'b00;
    end
    for (int i = 0; i < 20 && state_dbg == 3'b001; i++) begin
      n++;
      if (bus.eval_req) saw_req = 1'b1;
      step();
      bus.p2_valid = 1'b0;
    end
    chk({tag, ".collect_cycles"}, 8'(n), 8'd8);
    chk({tag, ".no_req"}, 8'(saw_req), 8'h0);
    chk({tag, ".upd_state"}, 8'(state_dbg), 8'h3);
    step();
  endtask

  initial begin
    reset           = 1'b1;
    match_start     = 1'b0;
    bus.p1_valid    = 1'b0;
    bus.p1_move     = 2'b00;
    bus.p2_valid    = 1'b0;
    bus.p2_move     = 2'b00;
    bus.eval_ack    = 1'b0;
    bus.eval_winner = 2'b00;
    #2;
    chk("rst.state", 8'(state_dbg), 8'h0);
    chk("rst.p1_ready", 8'(bus.p1_ready), 8'h0);
    chk("rst.eval_req", 8'(bus.eval_req), 8'h0);
    chk("rst.done", 8'(match_done), 8'h0);
    chk("rst.p1_score", 8'(p1_score), 8'h0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle.hold", 8'(state_dbg), 8'h0);

    // two rounds, P1 stone beats P2 scissors
    match_start = 1'b1;
    step();
    chk("m1.collect", 8'(state_dbg), 8'h1);
    chk("m1.p1_ready", 8'(bus.p1_ready), 8'h1);
    chk("m1.p2_ready", 8'(bus.p2_ready), 8'h1);
    play(2'b00, 2'b10, 2'b01, "m1r1");
    chk("m1r1.p1_score", 8'(p1_score), 8'd1);
    chk("m1r1.round", 8'(round_cnt), 8'd1);
    chk("m1r1.state", 8'(state_dbg), 8'h1);
    play(2'b00, 2'b10, 2'b01, "m1r2");
    chk("m1r2.p1_score", 8'(p1_score), 8'd2);
    chk("m1r2.p2_score", 8'(p2_score), 8'd0);
    chk("m1r2.round", 8'(round_cnt), 8'd2);
    chk("m1r2.done", 8'(match_done), 8'h1);
    chk("m1r2.winner", 8'(match_winner), 8'h1);
    chk("m1r2.state", 8'(state_dbg), 8'h4);
    step();
    chk("m1.done_hold", 8'(state_dbg), 8'h4);
    match_start = 1'b0;
    step();
    chk("m1.idle", 8'(state_dbg), 8'h0);
    chk("m1.done_fall", 8'(match_done), 8'h0);
    chk("m1.score_hold", 8'(p1_score), 8'd2);

    // invalid move held, then a real move; slow judge
    match_start = 1'b1;
    step();
    chk("m2.score_clr", 8'(p1_score), 8'd0);
    chk("m2.round_clr", 8'(round_cnt), 8'd0);
    chk("m2.collect", 8'(state_dbg), 8'h1);
    bus.p1_valid = 1'b1;
    bus.p1_move  = 2'b11;
    bus.p2_valid = 1'b1;
    bus.p2_move  = 2'b01;
    step();
    bus.p2_valid = 1'b0;
    chk("m2.p2_taken", 8'(bus.p2_ready), 8'h0);
    chk("m2.p1_ready11", 8'(bus.p1_ready), 8'h1);
    chk("m2.no_latch11", 8'(bus.eval_p1), 8'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m2.p1_ready11", 8'(bus.p1_ready), 8'h1);
      chk("m2.still_collect", 8'(state_dbg), 8'h1);
    end
    bus.p1_move = 2'b01;
    step();
    bus.p1_valid = 1'b0;
    chk("m2.eval", 8'(state_dbg), 8'h2);
    chk("m2.eval_p1", 8'(bus.eval_p1), 8'h1);
    chk("m2.eval_p2", 8'(bus.eval_p2), 8'h1);
    for (int i = 0; i < 5; i++) begin
      chk("m2.req_wait", 8'(bus.eval_req), 8'h1);
      chk("m2.p1_ready_wait", 8'(bus.p1_ready), 8'h0);
      chk("m2.p2_ready_wait", 8'(bus.p2_ready), 8'h0);
      chk("m2.p1_stable", 8'(bus.eval_p1), 8'h1);
      chk("m2.p2_stable", 8'(bus.eval_p2), 8'h1);
      step();
    end
    chk("m2.req6", 8'(bus.eval_req), 8'h1);
    bus.eval_ack    = 1'b1;
    bus.eval_winner = 2'b00;
    step();
    bus.eval_ack = 1'b0;
    chk("m2.update", 8'(state_dbg), 8'h3);
    step();
    chk("m2.round", 8'(round_cnt), 8'd1);
    chk("m2.tie_p1", 8'(p1_score), 8'd0);
    chk("m2.tie_p2", 8'(p2_score), 8'd0);
    chk("m2.back", 8'(state_dbg), 8'h1);

    // only P2 submits: timeout awards the round to P2
    timeout_round(1'b1, "m2t");
    chk("m2t.p2_score", 8'(p2_score), 8'd1);
    chk("m2t.p1_score", 8'(p1_score), 8'd0);
    chk("m2t.round", 8'(round_cnt), 8'd2);
    chk("m2t.state", 8'(state_dbg), 8'h1);

    // judge result 11 is a tie; round cap reached with P2 ahead
    play(2'b01, 2'b01, 2'b11, "m2r3");
    chk("m2r3.round", 8'(round_cnt), 8'd3);
    chk("m2r3.p2_score", 8'(p2_score), 8'd1);
    chk("m2r3.done", 8'(match_done), 8'h1);
    chk("m2r3.winner", 8'(match_winner), 8'h2);
    chk("m2r3.state", 8'(state_dbg), 8'h4);

    // all-tie match ends in a draw at the round cap
    match_start = 1'b0;
    step();
    match_start = 1'b1;
    step();
    chk("m3.p2_clr", 8'(p2_score), 8'd0);
    chk("m3.done_clr", 8'(match_done), 8'h0);
    chk("m3.winner_clr", 8'(match_winner), 8'h0);
    play(2'b00, 2'b00, 2'b00, "m3r1");
    chk("m3r1.round", 8'(round_cnt), 8'd1);
    timeout_round(1'b0, "m3t");
    chk("m3t.round", 8'(round_cnt), 8'd2);
    chk("m3t.p1_score", 8'(p1_score), 8'd0);
    chk("m3t.p2_score", 8'(p2_score), 8'd0);
    play(2'b10, 2'b10, 2'b11, "m3r3");
    chk("m3r3.round", 8'(round_cnt), 8'd3);
    chk("m3r3.p1_score", 8'(p1_score), 8'd0);
    chk("m3r3.p2_score", 8'(p2_score), 8'd0);
    chk("m3r3.done", 8'(match_done), 8'h1);
    chk("m3r3.winner", 8'(match_winner), 8'h0);

    // reset asserted mid-cycle during EVAL
    match_start = 1'b0;
    step();
    match_start = 1'b1;
    step();
    play(2'b10, 2'b01, 2'b01, "m4r1");
    chk("m4r1.p1_score", 8'(p1_score), 8'd1);
    bus.p1_valid = 1'b1;
    bus.p1_move  = 2'b01;
    bus.p2_valid = 1'b1;
    bus.p2_move  = 2'b00;
    step();
    bus.p1_valid = 1'b0;
    bus.p2_valid = 1'b0;
    chk("m4.eval", 8'(state_dbg), 8'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.state", 8'(state_dbg), 8'h0);
    chk("arst.p1_score", 8'(p1_score), 8'd0);
    chk("arst.round", 8'(round_cnt), 8'd0);
    chk("arst.eval_req", 8'(bus.eval_req), 8'h0);
    chk("arst.eval_p1", 8'(bus.eval_p1), 8'h0);
    chk("arst.eval_p2", 8'(bus.eval_p2), 8'h0);
    chk("arst.p1_ready", 8'(bus.p1_ready), 8'h0);
    chk("arst.done", 8'(match_done), 8'h0);
    chk("arst.winner", 8'(match_winner), 8'h0);
    match_start = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("m5.idle", 8'(state_dbg), 8'h0);
    match_start = 1'b1;
    step();
    chk("m5.collect", 8'(state_dbg), 8'h1);
    chk("m5.p1_score", 8'(p1_score), 8'd0);
    play(2'b01, 2'b00, 2'b01, "m5r1");
    chk("m5r1.p1_score", 8'(p1_score), 8'd1);
    chk("m5r1.round", 8'(round_cnt), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
